imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arbiter_rr_arb2.sv | 23 ++
 rtl/imem_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory arbiter: FSM states, owner tags,
// the bubble word and the byte-to-word address helper.
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Bit positions inside the one-hot grant vector returned by rr_arb2
  localparam int GNT_F = 0;
  localparam int GNT_L = 1;

  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and BRAM-side signals around the arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface imem_arbiter_if #(
  parameter int ADDR_W = 10
) ();

  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_stall;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              boot_done;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    output f_gnt, f_stall, f_rvalid, f_rdata,
    input  l_req, l_we, l_addr, l_wdata, boot_done,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    input  f_gnt, f_stall, f_rvalid, f_rdata,
    output l_req, l_we, l_addr, l_wdata, boot_done,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; purely combinational, the caller owns the
// last-owner register.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       i_req_f,
  input  logic       i_req_l,
  input  owner_e     i_last_owner,
  output logic [1:0] o_gnt
);

  // One-hot grant; on a tie the side that did not win last time is served
  always_comb begin
    o_gnt = 2'b00;
    case ({i_req_l, i_req_f})
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last_owner == OWN_FETCH) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction BRAM between the fetch stage and a
// loader/debug port, with a boot hold and a one-cycle read response pipeline.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  localparam state_e RESET_STATE = BOOT_HOLD ? ST_BOOT : ST_RUN;

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_last_owner;
  logic              w_f_elig;
  logic              w_l_elig;
  logic [1:0]        w_arb_gnt;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_any_gnt;
  logic [29:0]       w_f_word;
  logic [29:0]       w_l_word;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       w_sel_wdata;
  logic [31:0]       r_m_wdata;
  logic              r_f_pend;
  logic              r_l_pend;
  logic              w_f_rvalid;
  logic              w_l_rvalid;
  logic              w_unused_bits;

  assign w_f_word = word_of(bus.f_addr);
  assign w_l_word = word_of(bus.l_addr);

  // Address bits above the BRAM depth and the byte offset are deliberately dropped
  assign w_unused_bits = ^{w_f_word[29:ADDR_W], w_l_word[29:ADDR_W],
                           bus.f_addr[1:0], bus.l_addr[1:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state request eligibility
  always_comb begin
    w_state_nxt = r_state;
    w_f_elig    = 1'b0;
    w_l_elig    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_l_elig = bus.l_req;
        if (bus.boot_done) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_BOOT;
        end
      end
      ST_RUN: begin
        w_f_elig    = bus.f_req & ~bus.f_flush;
        w_l_elig    = bus.l_req;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .i_req_f      (w_f_elig),
    .i_req_l      (w_l_elig),
    .i_last_owner (r_last_owner),
    .o_gnt        (w_arb_gnt)
  );

  // Grants are masked while reset is held so no BRAM access leaks out
  assign w_f_gnt   = reset & w_arb_gnt[GNT_F];
  assign w_l_gnt   = reset & w_arb_gnt[GNT_L];
  assign w_any_gnt = w_f_gnt | w_l_gnt;

  // BRAM address/data mux; idle cycles repeat the last driven values
  always_comb begin
    w_sel_addr  = r_m_addr;
    w_sel_wdata = r_m_wdata;
    if (w_f_gnt) begin
      w_sel_addr = w_f_word[ADDR_W-1:0];
    end else if (w_l_gnt) begin
      w_sel_addr  = w_l_word[ADDR_W-1:0];
      w_sel_wdata = bus.l_wdata;
    end else begin
      w_sel_addr  = r_m_addr;
      w_sel_wdata = r_m_wdata;
    end
  end

  // Held address/data and round-robin history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_addr     <= '0;
      r_m_wdata    <= 32'h0000_0000;
      r_last_owner <= OWN_LOADER;
    end else begin
      r_m_addr  <= w_sel_addr;
      r_m_wdata <= w_sel_wdata;
      if (w_any_gnt) begin
        r_last_owner <= w_f_gnt ? OWN_FETCH : OWN_LOADER;
      end else begin
        r_last_owner <= r_last_owner;
      end
    end
  end

  // Outstanding-read flags; reset drops any response still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_pend <= 1'b0;
      r_l_pend <= 1'b0;
    end else begin
      r_f_pend <= w_f_gnt;
      r_l_pend <= w_l_gnt & ~bus.l_we;
    end
  end

  // A redirect in the response cycle turns the fetched word into a bubble
  assign w_f_rvalid = r_f_pend & ~bus.f_flush;
  assign w_l_rvalid = r_l_pend;

  assign bus.f_gnt    = w_f_gnt;
  assign bus.f_stall  = reset & bus.f_req & ~w_f_gnt;
  assign bus.f_rvalid = w_f_rvalid;
  assign bus.f_rdata  = w_f_rvalid ? bus.m_rdata : NOP_WORD;

  assign bus.l_gnt    = w_l_gnt;
  assign bus.l_rvalid = w_l_rvalid;
  assign bus.l_rdata  = w_l_rvalid ? bus.m_rdata : NOP_WORD;

  assign bus.m_en     = w_any_gnt;
  assign bus.m_we     = w_l_gnt & bus.l_we;
  assign bus.m_addr   = w_sel_addr;
  assign bus.m_wdata  = w_sel_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised bench for imem_arbiter: a behavioural BRAM plus a transaction-level
// reference model predicting grants, BRAM drive and read responses every cycle.
module tb_imem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus_if ();

  imem_arbiter #(
    .ADDR_W    (ADDR_W),
    .BOOT_HOLD (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Behavioural BRAM, reloaded with a known pattern whenever reset is held
  logic [31:0] bram [DEPTH];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
    end else if (bus_if.m_en) begin
      if (bus_if.m_we) bram[bus_if.m_addr] <= bus_if.m_wdata;
      else             bus_if.m_rdata <= bram[bus_if.m_addr];
    end
  end

  int n_tests;
  int n_fail;

  // Reference model state
  bit          booted;
  bit          last_fetch;
  bit          pf, pl;
  logic [31:0] pf_data, pl_data;
  int          hold_addr;
  logic [31:0] hold_wdata;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    booted     = 1'b0;
    last_fetch = 1'b0;
    pf         = 1'b0;
    pl         = 1'b0;
    pf_data    = 32'h0;
    pl_data    = 32'h0;
    hold_addr  = 0;
    hold_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic drive(input bit fr, input logic [31:0] fa, input bit ff, input bit lr,
                       input bit lw, input logic [31:0] la, input logic [31:0] ld, input bit bd);
    bus_if.f_req     = fr;
    bus_if.f_addr    = fa;
    bus_if.f_flush   = ff;
    bus_if.l_req     = lr;
    bus_if.l_we      = lw;
    bus_if.l_addr    = la;
    bus_if.l_wdata   = ld;
    bus_if.boot_done = bd;
  endtask

  // One clock cycle: drive, predict, compare, advance the model
  task automatic cycle(input bit fr, input logic [31:0] fa, input bit ff, input bit lr,
                       input bit lw, input logic [31:0] la, input logic [31:0] ld, input bit bd);
    bit f_el, l_el, eg_f, eg_l;
    int fidx, lidx, eaddr;
    logic [31:0] ewdata;
    @(negedge clk);
    drive(fr, fa, ff, lr, lw, la, ld, bd);
    #1;
    fidx = idx_of(fa);
    lidx = idx_of(la);
    f_el = booted && fr && !ff;
    l_el = lr;
    eg_f = (f_el && l_el) ? !last_fetch : f_el;
    eg_l = l_el && !eg_f;
    eaddr  = eg_f ? fidx : (eg_l ? lidx : hold_addr);
    ewdata = eg_l ? ld : hold_wdata;
    chk_eq("f_gnt",    bus_if.f_gnt,    eg_f);
    chk_eq("l_gnt",    bus_if.l_gnt,    eg_l);
    chk_eq("f_stall",  bus_if.f_stall,  fr && !eg_f);
    chk_eq("m_en",     bus_if.m_en,     eg_f || eg_l);
    chk_eq("m_we",     bus_if.m_we,     eg_l && lw);
    chk_eq("m_addr",   bus_if.m_addr,   eaddr);
    chk_eq("m_wdata",  bus_if.m_wdata,  ewdata);
    chk_eq("f_rvalid", bus_if.f_rvalid, pf && !ff);
    chk_eq("f_rdata",  bus_if.f_rdata,  (pf && !ff) ? pf_data : 32'h0);
    chk_eq("l_rvalid", bus_if.l_rvalid, pl);
    chk_eq("l_rdata",  bus_if.l_rdata,  pl ? pl_data : 32'h0);
    pf = eg_f;
    if (eg_f) pf_data = ref_mem[fidx];
    pl = eg_l && !lw;
    if (pl) pl_data = ref_mem[lidx];
    if (eg_l && lw) ref_mem[lidx] = ld;
    if (eg_f || eg_l) last_fetch = eg_f;
    hold_addr  = eaddr;
    hold_wdata = ewdata;
    if (!booted && bd) booted = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Assert reset with every requester active; all outputs must stay quiet
  task automatic reset_phase();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b1, 32'h0000_0208, 32'hDEAD_BEEF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_eq("rst_f_gnt",    bus_if.f_gnt,    1'b0);
      chk_eq("rst_l_gnt",    bus_if.l_gnt,    1'b0);
      chk_eq("rst_f_stall",  bus_if.f_stall,  1'b0);
      chk_eq("rst_f_rvalid", bus_if.f_rvalid, 1'b0);
      chk_eq("rst_l_rvalid", bus_if.l_rvalid, 1'b0);
      chk_eq("rst_f_rdata",  bus_if.f_rdata,  32'h0);
      chk_eq("rst_l_rdata",  bus_if.l_rdata,  32'h0);
      chk_eq("rst_m_en",     bus_if.m_en,     1'b0);
      chk_eq("rst_m_we",     bus_if.m_we,     1'b0);
      chk_eq("rst_m_addr",   bus_if.m_addr,   32'h0);
      chk_eq("rst_m_wdata",  bus_if.m_wdata,  32'h0);
      @(negedge clk);
    end
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a & 32'hFFFF_F03F;
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom % 4) != 0, rand_addr(), ($urandom % 6) == 0,
            ($urandom % 2) == 1, ($urandom % 2) == 1, rand_addr(), $urandom,
            ($urandom % 10) == 0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    reset_phase();

    // Boot hold: fetch stalls while the loader writes the first instruction
    cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0013, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0);

    // Contention: both sides requesting for six cycles
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h0000_0010 + 4 * i, 1'b0, 1'b1, 1'b0, 32'h0000_0080 + 4 * i, 32'h0, 1'b0);
    end

    // Flush in the response cycle, then wrap-around address
    cycle(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_1004, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();

    // Write followed immediately by a fetch of the same word
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);
    cycle(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0024, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();

    random_cycles(400);

    // Reset right after a fetch grant; the response must never appear
    cycle(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset_phase();
    idle();
    random_cycles(150);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
